i2c_status_target: RTL and testbench

- I2C target (responder) that exposes the pet's status to an external I2C controller. It is the counterpart of the controller-side I2C engines that already drive the OLED and the ADS1115.
- Sits beside the main FSM. It snapshots the needs values and FSM state into a read-only register map, and accepts a one-byte command register that the FSM can consume as a remote action request.
- Runs entirely in the `clk` domain by oversampling SCL/SDA. No clock stretching.

---
 rtl/i2c_status_target.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_i2c_status_target.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_status_target.sv
// i2c_status_target: I2C target exposing pet status as an 8-byte register map.
// Registers 0-6 are read-only status (snapshotted per read transaction),
// register 7 is a writable command byte surfaced on cmd_data/cmd_valid.
// SCL/SDA are oversampled in the clk domain; no clock stretching.
// Optional macro I2C_GLITCH_FILTER_EN adds a FILTER_LEN-sample counter filter
// on both lines after the synchronizer.
module i2c_status_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h42,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       scl,
  inout  logic       sda,
  input  logic [6:0] life,
  input  logic [6:0] food,
  input  logic [6:0] fun,
  input  logic [6:0] rest,
  input  logic       disease,
  input  logic       death,
  input  logic [3:0] state,
  input  logic [3:0] ind_select,
  output logic [7:0] cmd_data,
  output logic       cmd_valid,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK
  } fsm_t;

  fsm_t       fsm;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f;
  logic       scl_q, sda_q;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic       sda_oe;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] rx_next;
  logic       ack_hold;
  logic       rw;
  logic [2:0] ptr;
  logic [7:0] rd_byte;
  logic [6:0] snap_life, snap_food, snap_fun, snap_rest;
  logic [1:0] snap_flags;
  logic [3:0] snap_state, snap_sel;

  // Open-drain output: only ever pull low or release.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CW-1:0] scl_cnt, sda_cnt;
  logic          scl_flt, sda_flt;

  // Counter filter: level follows only after FILTER_LEN consecutive new samples.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      scl_flt <= 1'b1;
      sda_flt <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_sync[1] == scl_flt) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
        scl_flt <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + CW'(1);
      end
      if (sda_sync[1] == sda_flt) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
        sda_flt <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + CW'(1);
      end
    end
  end

  assign scl_f = scl_flt;
  assign sda_f = sda_flt;
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  // Previous-sample registers for edge and START/STOP detection.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_next   = {shreg[6:0], sda_f};

  // Register map read mux: snapshot for 0-6, live command byte for 7.
  always_comb begin
    rd_byte = cmd_data;
    case (ptr)
      3'd0:    rd_byte = {1'b0, snap_life};
      3'd1:    rd_byte = {1'b0, snap_food};
      3'd2:    rd_byte = {1'b0, snap_fun};
      3'd3:    rd_byte = {1'b0, snap_rest};
      3'd4:    rd_byte = {6'b0, snap_flags};
      3'd5:    rd_byte = {4'b0, snap_state};
      3'd6:    rd_byte = {4'b0, snap_sel};
      default: rd_byte = cmd_data;
    endcase
  end

  // Protocol FSM; SDA updates only on synchronized SCL falls.
  // ACK slots use ack_hold: first fall drives the ACK, the next fall ends it.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      fsm        <= S_IDLE;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      cmd_data   <= '0;
      cmd_valid  <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      ack_hold   <= 1'b0;
      rw         <= 1'b0;
      ptr        <= '0;
      snap_life  <= '0;
      snap_food  <= '0;
      snap_fun   <= '0;
      snap_rest  <= '0;
      snap_flags <= '0;
      snap_state <= '0;
      snap_sel   <= '0;
    end else begin
      cmd_valid <= 1'b0;
      if (start_det) begin
        fsm      <= S_ADDR;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        ack_hold <= 1'b0;
      end else if (stop_det) begin
        fsm      <= S_IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        ack_hold <= 1'b0;
      end else begin
        case (fsm)
          S_IDLE: begin
          end
          S_ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) fsm <= S_ADDR_ACK;
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_hold) begin
                if (shreg[7:1] == TARGET_ADDR) begin
                  sda_oe   <= 1'b1;
                  ack_hold <= 1'b1;
                  busy     <= 1'b1;
                  rw       <= shreg[0];
                  if (shreg[0]) begin
                    snap_life  <= life;
                    snap_food  <= food;
                    snap_fun   <= fun;
                    snap_rest  <= rest;
                    snap_flags <= {death, disease};
                    snap_state <= state;
                    snap_sel   <= ind_select;
                  end
                end else begin
                  fsm <= S_IDLE;
                end
              end else begin
                ack_hold <= 1'b0;
                bit_cnt  <= '0;
                if (rw) begin
                  fsm    <= S_RD_DATA;
                  sda_oe <= ~rd_byte[7];
                end else begin
                  fsm    <= S_PTR;
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          S_PTR: begin
            if (scl_rise) begin
              shreg   <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ptr <= rx_next[2:0];
                fsm <= S_PTR_ACK;
              end
            end
          end
          S_WR_DATA: begin
            if (scl_rise) begin
              shreg   <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (ptr == 3'd7) begin
                  cmd_data  <= rx_next;
                  cmd_valid <= 1'b1;
                end
                ptr <= ptr + 3'd1;
                fsm <= S_WR_ACK;
              end
            end
          end
          S_PTR_ACK, S_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_hold) begin
                sda_oe   <= 1'b1;
                ack_hold <= 1'b1;
              end else begin
                sda_oe   <= 1'b0;
                ack_hold <= 1'b0;
                bit_cnt  <= '0;
                fsm      <= S_WR_DATA;
              end
            end
          end
          S_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              // bit_cnt has wrapped to 0 once all 8 bits were clocked out
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                ptr    <= ptr + 3'd1;
                fsm    <= S_RD_ACK;
              end else begin
                sda_oe <= ~rd_byte[3'd7 - bit_cnt];
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise && sda_f) begin
              fsm <= S_IDLE;
            end else if (scl_fall) begin
              bit_cnt <= '0;
              sda_oe  <= ~rd_byte[7];
              fsm     <= S_RD_DATA;
            end
          end
          default: fsm <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_status_target.sv
// Testbench for i2c_status_target: bit-banged I2C controller with a
// transaction-level model of the register map, pointer and command byte.
`timescale 1ns/1ps
module tb_i2c_status_target;

  localparam int unsigned Q = 10;  // clk cycles per quarter SCL period
  localparam int PH_NONE = 0, PH_ADDR = 1, PH_PTR = 2, PH_DATA = 3, PH_READ = 4;

  logic       clk = 1'b0;
  logic       btn_reset, scl, tb_sda_low;
  logic [6:0] life, food, fun, rest;
  logic       disease, death;
  logic [3:0] state, ind_select;
  logic [7:0] cmd_data;
  logic       cmd_valid, busy;
  wire        sda;

  assign sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #10 clk = ~clk;

  i2c_status_target #(.TARGET_ADDR(7'h42), .FILTER_LEN(3)) dut (
    .clk(clk), .btn_reset(btn_reset), .scl(scl), .sda(sda),
    .life(life), .food(food), .fun(fun), .rest(rest),
    .disease(disease), .death(death), .state(state), .ind_select(ind_select),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  int         m_phase = PH_NONE;
  logic       m_busy = 1'b0;
  logic [2:0] m_ptr = '0;
  logic [7:0] m_cmd = '0;
  logic [7:0] m_snap [0:7];
  int         m_pulses = 0;
  int         vcnt = 0;
  logic [7:0] rd_buf [0:7];
  event       ack_ev;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] live_reg(input int i);
    case (i)
      0: return {1'b0, life};
      1: return {1'b0, food};
      2: return {1'b0, fun};
      3: return {1'b0, rest};
      4: return {6'b0, death, disease};
      5: return {4'b0, state};
      6: return {4'b0, ind_select};
      default: return 8'h00;
    endcase
  endfunction

  // Count every clk cycle cmd_valid is high.
  always @(negedge clk) if (cmd_valid === 1'b1) vcnt++;

  // Compare process: at every ACK slot, busy and cmd_data must match the model.
  initial begin
    forever begin
      @(ack_ev);
      check8("busy_at_ack", {7'b0, busy}, {7'b0, m_busy});
      check8("cmd_data_at_ack", cmd_data, m_cmd);
    end
  end

  task automatic bit_io(input logic b, input bit glitch, input bit is_ack, output logic r);
    repeat (Q) @(negedge clk);
    tb_sda_low = ~b;
    repeat (Q) @(negedge clk);
    scl = 1'b1;
    if (glitch) begin
      repeat (8) @(negedge clk);
      tb_sda_low = 1'b1;
      @(negedge clk);
      tb_sda_low = 1'b0;
      @(negedge clk);
    end else begin
      repeat (Q) @(negedge clk);
    end
    r = sda;
    if (is_ack) -> ack_ev;
    repeat (Q) @(negedge clk);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    repeat (Q) @(negedge clk);
    tb_sda_low = 1'b0;
    repeat (Q) @(negedge clk);
    scl = 1'b1;
    repeat (Q) @(negedge clk);
    tb_sda_low = 1'b1;
    repeat (Q) @(negedge clk);
    scl = 1'b0;
    m_phase = PH_ADDR;
    m_busy  = 1'b0;
  endtask

  task automatic i2c_stop();
    repeat (Q) @(negedge clk);
    tb_sda_low = 1'b1;
    repeat (Q) @(negedge clk);
    scl = 1'b1;
    repeat (Q) @(negedge clk);
    tb_sda_low = 1'b0;
    repeat (Q) @(negedge clk);
    m_phase = PH_NONE;
    m_busy  = 1'b0;
  endtask

  task automatic tx_byte(input logic [7:0] b, input int glitch_idx, output logic acked);
    logic r;
    logic exp_ack;
    for (int i = 7; i >= 0; i--) bit_io(b[i], (i == glitch_idx), 1'b0, r);
    exp_ack = 1'b0;
    case (m_phase)
      PH_ADDR: begin
        if (b[7:1] == 7'h42) begin
          exp_ack = 1'b1;
          m_busy  = 1'b1;
          if (b[0]) begin
            for (int k = 0; k < 7; k++) m_snap[k] = live_reg(k);
            m_phase = PH_READ;
          end else begin
            m_phase = PH_PTR;
          end
        end else begin
          m_phase = PH_NONE;
        end
      end
      PH_PTR: begin
        exp_ack = 1'b1;
        m_ptr   = b[2:0];
        m_phase = PH_DATA;
      end
      PH_DATA: begin
        exp_ack = 1'b1;
        if (m_ptr == 3'd7) begin
          m_cmd = b;
          m_pulses++;
        end
        m_ptr = m_ptr + 3'd1;
      end
      default: exp_ack = 1'b0;
    endcase
    bit_io(1'b1, 1'b0, 1'b1, r);
    acked = ~r;
    check8($sformatf("ack_for_0x%0h", b), {7'b0, acked}, {7'b0, exp_ack});
  endtask

  task automatic rx_byte(input bit ack, output logic [7:0] b);
    logic r;
    logic [7:0] exp;
    exp = (m_ptr == 3'd7) ? m_cmd : m_snap[m_ptr];
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, 1'b0, 1'b0, r);
      b[i] = r;
    end
    m_ptr = m_ptr + 3'd1;
    bit_io(~ack, 1'b0, 1'b1, r);
    check8("read_byte_model", b, exp);
    if (!ack) begin
      check8("sda_released_at_nack", {7'b0, r}, 8'h01);
      m_phase = PH_NONE;
    end
  endtask

  task automatic set_ptr(input logic [7:0] p);
    logic a;
    i2c_start();
    tx_byte(8'h84, -1, a);
    tx_byte(p, -1, a);
  endtask

  task automatic read_seq(input int n);
    logic a;
    logic [7:0] b;
    i2c_start();
    tx_byte(8'h85, -1, a);
    for (int i = 0; i < n; i++) begin
      rx_byte(i != n - 1, b);
      rd_buf[i] = b;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    logic a;
    logic [7:0] b;
    for (int k = 0; k < 8; k++) m_snap[k] = 8'h00;
    btn_reset = 1'b0; scl = 1'b1; tb_sda_low = 1'b0;
    life = 7'd87; food = 7'd40; fun = 7'd55; rest = 7'd99;
    disease = 1'b0; death = 1'b0; state = 4'd5; ind_select = 4'd2;
    repeat (5) @(negedge clk);

    // Reset state
    check8("reset_sda", {7'b0, sda}, 8'h01);
    check8("reset_busy", {7'b0, busy}, 8'h00);
    check8("reset_cmd_valid", {7'b0, cmd_valid}, 8'h00);
    check8("reset_cmd_data", cmd_data, 8'h00);
    btn_reset = 1'b1;
    repeat (10) @(negedge clk);

    // Read life and food
    set_ptr(8'h00);
    read_seq(2);
    check8("life_byte", rd_buf[0], 8'h57);
    check8("food_byte", rd_buf[1], 8'h28);
    i2c_stop();

    // Snapshot coherence: food changes after the read address is ACKed
    set_ptr(8'h00);
    i2c_start();
    tx_byte(8'h85, -1, a);
    food = 7'd10;
    for (int i = 0; i < 4; i++) begin
      rx_byte(i != 3, b);
      rd_buf[i] = b;
    end
    check8("snapshot_food", rd_buf[1], 8'h28);
    check8("snapshot_rest", rd_buf[3], 8'h63);
    i2c_stop();

    // Command write and read-back of register 7
    v0 = vcnt;
    set_ptr(8'h07);
    tx_byte(8'hA5, -1, a);
    i2c_stop();
    check8("cmd_data_written", cmd_data, 8'hA5);
    check_int("cmd_valid_cycles_write", vcnt - v0, 1);
    set_ptr(8'h07);
    read_seq(1);
    check8("reg7_readback", rd_buf[0], 8'hA5);
    i2c_stop();

    // Address mismatch
    v0 = vcnt;
    i2c_start();
    tx_byte(8'h86, -1, a);
    check8("mismatch_nack", {7'b0, a}, 8'h00);
    tx_byte(8'h07, -1, a);
    check8("mismatch_busy", {7'b0, busy}, 8'h00);
    i2c_stop();
    check_int("mismatch_no_cmd_valid", vcnt - v0, 0);

    // Pointer wrap 6,7,0 and flag register
    life = 7'd1; ind_select = 4'd3; disease = 1'b1; death = 1'b0;
    set_ptr(8'h06);
    read_seq(3);
    check8("wrap_reg6", rd_buf[0], 8'h03);
    check8("wrap_reg7", rd_buf[1], 8'hA5);
    check8("wrap_reg0", rd_buf[2], 8'h01);
    i2c_stop();
    set_ptr(8'h04);
    read_seq(1);
    check8("flags_reg4", rd_buf[0], 8'h01);
    i2c_stop();

`ifdef I2C_GLITCH_FILTER_EN
    // A 1-clk SDA low pulse during SCL high must not abort the write
    v0 = vcnt;
    set_ptr(8'h07);
    tx_byte(8'h3C, 5, a);
    check8("glitch_ack", {7'b0, a}, 8'h01);
    i2c_stop();
    check8("glitch_cmd_data", cmd_data, 8'h3C);
    check_int("glitch_cmd_valid_cycles", vcnt - v0, 1);
`endif

    // Reset mid-read while SDA is driven low (bit 7 of life)
    set_ptr(8'h00);
    i2c_start();
    tx_byte(8'h85, -1, a);
    repeat (Q) @(negedge clk);
    check8("sda_driven_before_reset", {7'b0, sda}, 8'h00);
    btn_reset = 1'b0;
    #1;
    check8("sda_released_in_reset", {7'b0, sda}, 8'h01);
    check8("busy_in_reset", {7'b0, busy}, 8'h00);
    check8("cmd_data_in_reset", cmd_data, 8'h00);
    m_ptr = '0; m_cmd = '0; m_busy = 1'b0; m_phase = PH_NONE;
    repeat (3) @(negedge clk);
    btn_reset = 1'b1;
    i2c_stop();
    read_seq(1);
    check8("post_reset_ptr0", rd_buf[0], 8'h01);
    i2c_stop();

    check_int("cmd_valid_total_cycles", vcnt, m_pulses);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
